// File: rtl/sync_2ff.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_2ff: two-flop synchronizer for an asynchronous level input. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/btn_pulse_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btn_pulse_gen: debounces a raw push-button and emits one-cycle   |
// | strobes per press, with optional auto-repeat while held.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module btn_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse,
  output logic held
);

  localparam int c_MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int c_MAX_CYC = (c_MAX_DR > REPEAT_PERIOD) ? c_MAX_DR : REPEAT_PERIOD;
  localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

  localparam logic [c_CNT_W-1:0] c_DB_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_DLY_LAST = c_CNT_W'(REPEAT_DELAY - 1);
  localparam logic [c_CNT_W-1:0] c_PER_LAST = c_CNT_W'(REPEAT_PERIOD - 1);

  localparam logic [2:0] c_IDLE       = 3'd0;
  localparam logic [2:0] c_DB_PRESS   = 3'd1;
  localparam logic [2:0] c_PRESSED    = 3'd2;
  localparam logic [2:0] c_REPEAT     = 3'd3;
  localparam logic [2:0] c_DB_RELEASE = 3'd4;

  logic               w_btn_s;
  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_pulse;
  logic               r_held;
  logic               w_pulse_nxt;
  logic               w_held_nxt;
  logic               w_db_done;
  logic               w_dly_done;
  logic               w_per_done;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (btn),
    .o_q   (w_btn_s)
  );

  assign w_db_done  = (r_cnt == c_DB_LAST);
  assign w_dly_done = (r_cnt == c_DLY_LAST);
  assign w_per_done = (r_cnt == c_PER_LAST);

  // Next state and shared counter; every state change clears the counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    case (r_state)
      c_IDLE: begin
        w_cnt_nxt = '0;
        if (w_btn_s) w_state_nxt = c_DB_PRESS;
      end
      c_DB_PRESS: begin
        if (!w_btn_s) begin
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_db_done) begin
          w_state_nxt = c_PRESSED;
          w_cnt_nxt   = '0;
        end
      end
      c_PRESSED: begin
        if (!w_btn_s) begin
          w_state_nxt = c_DB_RELEASE;
          w_cnt_nxt   = '0;
        end else if (!REPEAT_EN) begin
          w_cnt_nxt = '0;
        end else if (w_dly_done) begin
          w_state_nxt = c_REPEAT;
          w_cnt_nxt   = '0;
        end
      end
      c_REPEAT: begin
        if (!w_btn_s) begin
          w_state_nxt = c_DB_RELEASE;
          w_cnt_nxt   = '0;
        end else if (w_per_done) begin
          w_cnt_nxt = '0;
        end
      end
      c_DB_RELEASE: begin
        if (w_btn_s) begin
          w_state_nxt = c_PRESSED;
          w_cnt_nxt   = '0;
        end else if (w_db_done) begin
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Strobes fire only on accepting a press or on a repeat tick, never on release.
  always_comb begin
    w_pulse_nxt = 1'b0;
    case (r_state)
      c_DB_PRESS: w_pulse_nxt = w_btn_s && w_db_done;
      c_PRESSED:  w_pulse_nxt = w_btn_s && REPEAT_EN && w_dly_done;
      c_REPEAT:   w_pulse_nxt = w_btn_s && w_per_done;
      default:    w_pulse_nxt = 1'b0;
    endcase
    w_held_nxt = (w_state_nxt == c_PRESSED) || (w_state_nxt == c_REPEAT) ||
                 (w_state_nxt == c_DB_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_held  <= w_held_nxt;
    end
  end

  assign pulse = r_pulse;
  assign held  = r_held;

endmodule
`default_nettype wire

// File: tb/tb_btn_pulse_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_btn_pulse_gen: directed bench for btn_pulse_gen, one instance |
// | without and one with auto-repeat, plus a 4-phase LED consumer.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_btn_pulse_gen;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn   = 1'b0;
  logic p0, h0, p1, h1;
  logic [1:0] phase;
  logic led;
  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  btn_pulse_gen #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_EN       (1'b0),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .pulse (p0),
    .held  (h0)
  );

  btn_pulse_gen #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_EN       (1'b1),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut_rpt (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .pulse (p1),
    .held  (h1)
  );

  // 4-phase LED counter driven by the non-repeating instance.
  always_ff @(posedge clk) begin
    if (!rst_n)  phase <= 2'd0;
    else if (p0) phase <= phase + 2'd1;
  end
  assign led = (phase == 2'd3);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Repeating instance: press strobe after E6, then E14 and every 3 edges.
  function automatic logic rpt_exp(input int i);
    return (i == 6) || (i >= 14 && ((i - 14) % 3) == 0);
  endfunction

  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;
    step(3);
    check("rst_p0", p0, 0);
    check("rst_h0", h0, 0);
    check("rst_p1", p1, 0);
    check("rst_h1", h1, 0);
    rst_n = 1'b1;
    step(3);

    btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      check($sformatf("press_p0[%0d]", i), p0, (i == 6));
      check($sformatf("press_h0[%0d]", i), h0, (i >= 6));
      check($sformatf("press_p1[%0d]", i), p1, rpt_exp(i));
      check($sformatf("press_h1[%0d]", i), h1, (i >= 6));
    end

    // Release bounce: low 3, high 2, then low for good (final fall sampled at F5).
    for (int j = 0; j < 16; j++) begin
      btn = (j == 3 || j == 4);
      step();
      check($sformatf("rel_p0[%0d]", j), p0, 0);
      check($sformatf("rel_p1[%0d]", j), p1, (j == 1));
      check($sformatf("rel_h0[%0d]", j), h0, (j < 11));
      check($sformatf("rel_h1[%0d]", j), h1, (j < 11));
    end

    for (int j = 0; j < 16; j++) begin
      btn = (j < 2 || j == 4 || j == 5);
      step();
      check($sformatf("bnc_p0[%0d]", j), p0, 0);
      check($sformatf("bnc_h0[%0d]", j), h0, 0);
      check($sformatf("bnc_p1[%0d]", j), p1, 0);
      check($sformatf("bnc_h1[%0d]", j), h1, 0);
    end

    // Hold into REPEAT, reset on the edge that would carry a repeat strobe.
    btn = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      check($sformatf("pre_rst_p1[%0d]", i), p1, rpt_exp(i));
      check($sformatf("pre_rst_h1[%0d]", i), h1, (i >= 6));
    end
    rst_n = 1'b0;
    step();
    check("midrst_p0", p0, 0);
    check("midrst_h0", h0, 0);
    check("midrst_p1", p1, 0);
    check("midrst_h1", h1, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step();
      check($sformatf("post_rst_p0[%0d]", k), p0, (k == 6));
      check($sformatf("post_rst_h0[%0d]", k), h0, (k >= 6));
      check($sformatf("post_rst_p1[%0d]", k), p1, (k == 6));
      check($sformatf("post_rst_h1[%0d]", k), h1, (k >= 6));
    end
    btn = 1'b0;
    step(12);
    check("idle_h0", h0, 0);
    check("idle_h1", h1, 0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(2);
    check("led_start", led, 0);
    for (int k = 1; k <= 4; k++) begin
      btn = 1'b1;
      step(10);
      btn = 1'b0;
      step(10);
      check($sformatf("led_after_%0d", k), led, (k == 3));
      check($sformatf("led_held_%0d", k), h0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
